// File: rtl/seq_text_pkg.sv
// seq_text_pkg
//   Shared constants and types for the sequential text writer.
//   - Control characters recognised by the writer (newline, backspace, space).
//   - FSM state encoding.
//   - Character classification handed from the writer to the cursor arithmetic.
package seq_text_pkg;

    localparam logic [7:0] CHAR_NL    = 8'h0A;
    localparam logic [7:0] CHAR_BS    = 8'h08;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_CLEAR  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CLS_CHAR = 2'd0,
        CLS_NL   = 2'd1,
        CLS_BS   = 2'd2
    } char_class_t;

endpackage

// File: rtl/seq_cursor_next.sv
// seq_cursor_next
//   Combinational cursor arithmetic for one accepted character.
//   Ports:
//     cursor      in  current write address
//     base        in  session base address (line starts are relative to it)
//     char_class  in  ordinary character / newline / backspace
//     next_cursor out cursor after this character
//     wr_en       out this character produces a RAM write
//     wr_addr     out address of that write
//     wrap        out forward move crossed DEPTH-1 -> 0
module seq_cursor_next
    import seq_text_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int DEPTH    = 4096,
    parameter int LINE_LEN = 64
) (
    input  logic [ADDR_W-1:0] cursor,
    input  logic [ADDR_W-1:0] base,
    input  char_class_t       char_class,
    output logic [ADDR_W-1:0] next_cursor,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wrap
);

    localparam logic [ADDR_W-1:0] MASK      = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_LEN - 1);
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LINE_X    = (ADDR_W + 1)'(LINE_LEN);

    // Position inside the current row. LINE_LEN divides DEPTH, so the
    // low bits of the raw difference equal those of the modulo-DEPTH offset.
    logic [ADDR_W-1:0] line_pos;
    // Forward step (1 for a character, up to LINE_LEN for a newline) and the
    // unwrapped sum; the extra bit makes the DEPTH crossing visible.
    logic [ADDR_W:0]   step;
    logic [ADDR_W:0]   fwd_sum;

    always_comb begin
        line_pos = (cursor - base) & LINE_MASK;
        if (char_class == CLS_NL) begin
            step = LINE_X - {1'b0, line_pos};
        end else begin
            step = (ADDR_W + 1)'(1);
        end
        fwd_sum = {1'b0, cursor} + step;

        next_cursor = cursor;
        wr_en       = 1'b0;
        wr_addr     = cursor;
        wrap        = 1'b0;

        case (char_class)
            CLS_CHAR, CLS_NL: begin
                next_cursor = fwd_sum[ADDR_W-1:0] & MASK;
                wrap        = (fwd_sum >= DEPTH_X);
                wr_en       = (char_class == CLS_CHAR);
            end
            CLS_BS: begin
                // Backspace stops at the session base and never signals wrap.
                if (cursor != base) begin
                    next_cursor = (cursor - 1'b1) & MASK;
                    wr_en       = 1'b1;
                    wr_addr     = (cursor - 1'b1) & MASK;
                end
            end
            default: begin
                next_cursor = cursor;
            end
        endcase
    end

endmodule

// File: rtl/seq_text_writer.sv
// seq_text_writer
//   Streams ASCII characters into a text RAM through a single write port.
//   Handshake: a character transfers on a rising edge where char_valid and
//   char_ready are both high; char_ready depends only on state, never on
//   char_valid. start / clear_req take priority over a character offered in
//   the same cycle, which is then dropped.
//   Ports:
//     clk, resetn           clock, asynchronous active-low reset
//     start, base_addr      open a session at base_addr
//     clear_req, clear_len  fill clear_len locations from base with CLEAR_CHAR
//     char_valid/char_data  character input, char_ready accept
//     mem_addr/data/wren    registered RAM write port
//     cursor                next write address
//     busy                  clear in progress
//     wrap                  one-cycle pulse when the cursor wraps forward
//     dbg_state             current FSM state
module seq_text_writer
    import seq_text_pkg::*;
#(
    parameter int               DATA_W     = 8,
    parameter int               ADDR_W     = 12,
    parameter int               DEPTH      = 4096,
    parameter int               LINE_LEN   = 64,
    parameter logic [DATA_W-1:0] CLEAR_CHAR = DATA_W'(CHAR_SPACE)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              clear_req,
    input  logic [ADDR_W-1:0] clear_len,
    input  logic              char_valid,
    input  logic [DATA_W-1:0] char_data,
    output logic              char_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] cursor,
    output logic              busy,
    output logic              wrap,
    output state_t            dbg_state
);

    localparam logic [ADDR_W-1:0] MASK = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] clr_len;

    char_class_t       cls;
    logic [ADDR_W-1:0] nx_cursor;
    logic              nx_wr;
    logic [ADDR_W-1:0] nx_addr;
    logic              nx_wrap;

    always_comb begin
        cls = CLS_CHAR;
        if (char_data == DATA_W'(CHAR_NL)) begin
            cls = CLS_NL;
        end else if (char_data == DATA_W'(CHAR_BS)) begin
            cls = CLS_BS;
        end
    end

    seq_cursor_next #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .LINE_LEN (LINE_LEN)
    ) u_next (
        .cursor      (cursor),
        .base        (base),
        .char_class  (cls),
        .next_cursor (nx_cursor),
        .wr_en       (nx_wr),
        .wr_addr     (nx_addr),
        .wrap        (nx_wrap)
    );

    // Pure state decodes of a registered state: glitch-free.
    assign char_ready = (state == ST_ACTIVE);
    assign busy       = (state == ST_CLEAR);
    assign dbg_state  = state;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            cursor   <= '0;
            base     <= '0;
            clr_cnt  <= '0;
            clr_len  <= '0;
            mem_addr <= '0;
            mem_data <= '0;
            mem_wren <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            mem_wren <= 1'b0;
            wrap     <= 1'b0;
            case (state)
                ST_IDLE, ST_ACTIVE: begin
                    if (start) begin
                        base   <= base_addr & MASK;
                        cursor <= base_addr & MASK;
                    end
                    if (clear_req) begin
                        // The CLEAR state reads base, so a simultaneous start
                        // is already visible when the first fill is issued.
                        clr_cnt <= '0;
                        clr_len <= clear_len;
                        if (clear_len == '0) begin
                            state <= ST_ACTIVE;
                            if (!start) begin
                                cursor <= base;
                            end
                        end else begin
                            state <= ST_CLEAR;
                        end
                    end else if (start) begin
                        state <= ST_ACTIVE;
                    end else if (state == ST_ACTIVE && char_valid) begin
                        cursor <= nx_cursor;
                        wrap   <= nx_wrap;
                        if (nx_wr) begin
                            mem_wren <= 1'b1;
                            mem_addr <= nx_addr;
                            mem_data <= (cls == CLS_BS) ? CLEAR_CHAR : char_data;
                        end
                    end
                end
                ST_CLEAR: begin
                    mem_wren <= 1'b1;
                    mem_addr <= (base + clr_cnt) & MASK;
                    mem_data <= CLEAR_CHAR;
                    clr_cnt  <= clr_cnt + 1'b1;
                    if (clr_cnt == clr_len - 1'b1) begin
                        state  <= ST_ACTIVE;
                        cursor <= base;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_text_writer.sv
module tb_seq_text_writer;
    import seq_text_pkg::*;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 12;
    localparam int DEPTH    = 4096;
    localparam int LINE_LEN = 64;
    localparam logic [7:0] FILL = 8'h20;

    localparam int M_IDLE   = 0;
    localparam int M_ACTIVE = 1;
    localparam int M_CLEAR  = 2;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              clear_req = 1'b0;
    logic [ADDR_W-1:0] clear_len = '0;
    logic              char_valid = 1'b0;
    logic [DATA_W-1:0] char_data = '0;
    logic              char_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [ADDR_W-1:0] cursor;
    logic              busy;
    logic              wrap;
    state_t            dbg_state;

    always #5 clk = ~clk;

    seq_text_writer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LINE_LEN(LINE_LEN), .CLEAR_CHAR(FILL)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
        .clear_req(clear_req), .clear_len(clear_len), .char_valid(char_valid),
        .char_data(char_data), .char_ready(char_ready), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_wren(mem_wren), .cursor(cursor), .busy(busy),
        .wrap(wrap), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_state, m_cursor, m_base, m_left;
    bit m_wren, m_wrap;

    task automatic model_reset();
        m_state = M_IDLE; m_cursor = 0; m_base = 0; m_left = 0;
        m_wren = 0; m_wrap = 0;
    endtask

    task automatic model_edge();
        int off, nc;
        m_wren = 0;
        m_wrap = 0;
        if (m_state == M_CLEAR) begin
            m_wren = 1;
            m_left--;
            if (m_left == 0) begin
                m_state  = M_ACTIVE;
                m_cursor = m_base;
            end
        end else begin
            if (start) begin
                m_base   = int'(base_addr) % DEPTH;
                m_cursor = m_base;
            end
            if (clear_req) begin
                for (int i = 0; i < int'(clear_len); i++)
                    exp_q.push_back({ADDR_W'((m_base + i) % DEPTH), FILL});
                if (clear_len == 0) begin
                    m_state  = M_ACTIVE;
                    m_cursor = m_base;
                end else begin
                    m_state = M_CLEAR;
                    m_left  = int'(clear_len);
                end
            end else if (start) begin
                m_state = M_ACTIVE;
            end else if (m_state == M_ACTIVE && char_valid) begin
                if (char_data == 8'h0A) begin
                    off = (m_cursor - m_base + DEPTH) % DEPTH;
                    nc  = (m_base + (off / LINE_LEN) * LINE_LEN + LINE_LEN) % DEPTH;
                    m_wrap   = (nc <= m_cursor);  // forward move landed at or below start
                    m_cursor = nc;
                end else if (char_data == 8'h08) begin
                    if (m_cursor != m_base) begin
                        m_cursor = (m_cursor + DEPTH - 1) % DEPTH;
                        m_wren   = 1;
                        exp_q.push_back({ADDR_W'(m_cursor), FILL});
                    end
                end else begin
                    m_wren = 1;
                    exp_q.push_back({ADDR_W'(m_cursor), char_data});
                    m_wrap   = (m_cursor == DEPTH - 1);
                    m_cursor = (m_cursor + 1) % DEPTH;
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic st, input logic clr, input logic [ADDR_W-1:0] len,
                         input logic [ADDR_W-1:0] ba, input logic v, input logic [DATA_W-1:0] d);
        start = st; clear_req = clr; clear_len = len; base_addr = ba;
        char_valid = v; char_data = d;
    endtask

    // One clock: model consumes the inputs the DUT samples, then outputs are compared.
    task automatic cycle();
        logic [ADDR_W+DATA_W-1:0] item;
        state_t exp_st;
        if (resetn) model_edge();
        @(posedge clk);
        #1;
        exp_st = (m_state == M_ACTIVE) ? ST_ACTIVE : (m_state == M_CLEAR) ? ST_CLEAR : ST_IDLE;
        check("state", 32'(dbg_state), 32'(exp_st));
        check("char_ready", 32'(char_ready), 32'(m_state == M_ACTIVE));
        check("busy", 32'(busy), 32'(m_state == M_CLEAR));
        check("cursor", 32'(cursor), 32'(m_cursor));
        check("mem_wren", 32'(mem_wren), 32'(m_wren));
        check("wrap", 32'(wrap), 32'(m_wrap));
        if (m_wren) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(1), 32'(0));
            end else begin
                item = exp_q.pop_front();
                if (mem_wren) begin
                    check("mem_addr", 32'(mem_addr), 32'(item[ADDR_W+DATA_W-1:DATA_W]));
                    check("mem_data", 32'(mem_data), 32'(item[DATA_W-1:0]));
                end
            end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic st; logic clr; logic [ADDR_W-1:0] len; logic [ADDR_W-1:0] ba;
        logic v; logic [DATA_W-1:0] d;
        logic [ADDR_W-1:0] e_cur; logic e_wren; logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_data; logic e_wrap; logic e_ready; logic e_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic st, input logic clr, input int len, input int ba,
                                input logic v, input int d, input int e_cur, input logic e_wren,
                                input int e_addr, input int e_data, input logic e_wrap,
                                input logic e_ready, input logic e_busy);
        vec_t r;
        r.st = st; r.clr = clr; r.len = ADDR_W'(len); r.ba = ADDR_W'(ba);
        r.v = v; r.d = DATA_W'(d); r.e_cur = ADDR_W'(e_cur); r.e_wren = e_wren;
        r.e_addr = ADDR_W'(e_addr); r.e_data = DATA_W'(e_data); r.e_wrap = e_wrap;
        r.e_ready = e_ready; r.e_busy = e_busy;
        return r;
    endfunction

    initial begin
        int r;
        // "HI" from 0x100, then three more chars to reach 0x105
        tbl.push_back(mk(1,0,0,'h100, 0,0,    'h100,0,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,     1,'h48, 'h101,1,'h100,'h48,0,1,0));
        tbl.push_back(mk(0,0,0,0,     1,'h49, 'h102,1,'h101,'h49,0,1,0));
        tbl.push_back(mk(0,0,0,0,     1,'h61, 'h103,1,'h102,'h61,0,1,0));
        tbl.push_back(mk(0,0,0,0,     1,'h62, 'h104,1,'h103,'h62,0,1,0));
        tbl.push_back(mk(0,0,0,0,     1,'h63, 'h105,1,'h104,'h63,0,1,0));
        // two newlines
        tbl.push_back(mk(0,0,0,0,     1,'h0A, 'h140,0,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,     1,'h0A, 'h180,0,0,0,0,1,0));
        // backspace at base, then 'A' and backspace
        tbl.push_back(mk(1,0,0,'h100, 0,0,    'h100,0,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,     1,'h08, 'h100,0,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,     1,'h41, 'h101,1,'h100,'h41,0,1,0));
        tbl.push_back(mk(0,0,0,0,     1,'h08, 'h100,1,'h100,'h20,0,1,0));
        // start at 0xFFE with a character offered (dropped), then wrap
        tbl.push_back(mk(1,0,0,'hFFE, 1,'h5A, 'hFFE,0,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,     1,'h58, 'hFFF,1,'hFFE,'h58,0,1,0));
        tbl.push_back(mk(0,0,0,0,     1,'h59, 'h000,1,'hFFF,'h59,1,1,0));
        tbl.push_back(mk(0,0,0,0,     1,'h57, 'h001,1,'h000,'h57,0,1,0));
        // clear 4 from 0x200 with char_valid held high
        tbl.push_back(mk(1,0,0,'h200, 0,0,    'h200,0,0,0,0,1,0));
        tbl.push_back(mk(0,1,4,0,     1,'h71, 'h200,0,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,     1,'h71, 'h200,1,'h200,'h20,0,0,1));
        tbl.push_back(mk(0,0,0,0,     1,'h71, 'h200,1,'h201,'h20,0,0,1));
        tbl.push_back(mk(0,0,0,0,     1,'h71, 'h200,1,'h202,'h20,0,0,1));
        tbl.push_back(mk(0,0,0,0,     1,'h71, 'h200,1,'h203,'h20,0,1,0));
        // clear_len = 0
        tbl.push_back(mk(0,1,0,0,     0,0,    'h200,0,0,0,0,1,0));
        // start + clear together: fill from the new base
        tbl.push_back(mk(1,1,2,'h300, 0,0,    'h300,0,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,     0,0,    'h300,1,'h300,'h20,0,0,1));
        tbl.push_back(mk(0,0,0,0,     0,0,    'h300,1,'h301,'h20,0,1,0));

        // ---- reset state ----
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check("rst_wren", 32'(mem_wren), 0);
        check("rst_ready", 32'(char_ready), 0);
        check("rst_cursor", 32'(cursor), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        resetn = 1'b1;

        // idle ignores characters
        drive(0,0,0,0,1,8'h41);
        cycle();

        // ---- table ----
        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].clr, tbl[i].len, tbl[i].ba, tbl[i].v, tbl[i].d);
            cycle();
            check($sformatf("v%0d_cursor", i), 32'(cursor), 32'(tbl[i].e_cur));
            check($sformatf("v%0d_wren", i), 32'(mem_wren), 32'(tbl[i].e_wren));
            if (tbl[i].e_wren) begin
                check($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(tbl[i].e_addr));
                check($sformatf("v%0d_data", i), 32'(mem_data), 32'(tbl[i].e_data));
            end
            check($sformatf("v%0d_wrap", i), 32'(wrap), 32'(tbl[i].e_wrap));
            check($sformatf("v%0d_ready", i), 32'(char_ready), 32'(tbl[i].e_ready));
            check($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
        end

        // ---- reset in the middle of a clear ----
        drive(1,1,4,12'h200,0,0);
        cycle();
        drive(0,0,0,0,0,0);
        cycle();
        cycle();
        check("mid_wren_before", 32'(mem_wren), 1);
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_wren", 32'(mem_wren), 0);
        check("mid_rst_addr", 32'(mem_addr), 0);
        check("mid_rst_data", 32'(mem_data), 0);
        check("mid_rst_cursor", 32'(cursor), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_ready", 32'(char_ready), 0);
        model_reset();
        exp_q.delete();
        @(negedge clk);
        resetn = 1'b1;
        drive(0,0,0,0,1,8'h42);
        cycle();
        check("post_rst_ready", 32'(char_ready), 0);
        check("post_rst_wren", 32'(mem_wren), 0);
        cycle();

        // ---- randomized traffic against the model ----
        drive(1,0,0,12'h010,0,0);
        cycle();
        for (int n = 0; n < 600; n++) begin
            logic st, clr, v;
            logic [ADDR_W-1:0] ba, len;
            logic [DATA_W-1:0] d;
            st  = ($urandom_range(0, 15) == 0);
            clr = ($urandom_range(0, 31) == 0);
            len = ADDR_W'($urandom_range(0, 6));
            ba  = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(12'hFC0, 12'hFFF))
                                              : ADDR_W'($urandom_range(0, DEPTH - 1));
            v   = ($urandom_range(0, 3) != 0);
            r   = $urandom_range(0, 15);
            if (r < 2)      d = 8'h0A;
            else if (r < 4) d = 8'h08;
            else            d = DATA_W'($urandom_range(8'h21, 8'h7E));
            drive(st, clr, len, ba, v, d);
            cycle();
        end
        drive(0,0,0,0,0,0);
        for (int n = 0; n < 8; n++) cycle();
        check("sb_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
